// File: rtl/turbo_pkg.sv
// Constants and FSM encoding shared by the CRC24 attach block and the turbo interleaver.
package turbo_pkg;

    localparam logic [23:0] POLY      = 24'h800063;
    localparam int          PAY_SMALL = 129;
    localparam int          PAY_LARGE = 765;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PAYLOAD = 3'd1,
        CRC0    = 3'd2,
        CRC1    = 3'd3,
        CRC2    = 3'd4
    } state_t;

endpackage

// File: rtl/crc24_byte.sv
// Combinational CRC24 advance by one byte, MSB first, no reflection.
module crc24_byte #(
    parameter logic [23:0] POLY = 24'h800063
) (
    input  logic [23:0] crc_in,
    input  logic [7:0]  byte_in,
    output logic [23:0] crc_out
);

    logic [23:0] c;
    logic        fb;

    always_comb begin
        c  = crc_in;
        fb = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            fb = c[23] ^ byte_in[i];
            c  = {c[22:0], 1'b0} ^ (fb ? POLY : 24'h000000);
        end
        crc_out = c;
    end

endmodule

// File: rtl/crc24_attach.sv
// Passes a payload block through with one cycle latency and appends its 3-byte CRC24.
// in_ready follows ds_ready only between blocks; once started a block runs to completion.
module crc24_attach #(
    parameter logic [23:0] POLY      = turbo_pkg::POLY,
    parameter int          PAY_SMALL = turbo_pkg::PAY_SMALL,
    parameter int          PAY_LARGE = turbo_pkg::PAY_LARGE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       in_valid,
    input  logic       in_start,
    input  logic       in_blocksize,
    output logic       in_ready,
    input  logic       ds_ready,
    output logic [7:0] data_out,
    output logic       out_valid,
    output logic       CRC_start,
    output logic       CRC_blocksize,
    output logic       CRC_end,
    output logic       err
);

    import turbo_pkg::*;

    localparam logic [9:0] LIM_SMALL = 10'(PAY_SMALL);
    localparam logic [9:0] LIM_LARGE = 10'(PAY_LARGE);

    state_t      state;
    logic [9:0]  cnt;
    logic [9:0]  cnt_inc;
    logic [9:0]  limit;
    logic [23:0] crc;
    logic [23:0] crc_seed;
    logic [23:0] crc_nxt;
    logic        xfer;

    assign in_ready = (state == IDLE) ? ds_ready : (state == PAYLOAD);
    assign xfer     = in_valid & in_ready;
    assign cnt_inc  = cnt + 10'd1;
    // CRC_blocksize doubles as the latched size for the whole block
    assign limit    = CRC_blocksize ? LIM_LARGE : LIM_SMALL;
    assign crc_seed = (state == IDLE) ? 24'h000000 : crc;

    crc24_byte #(.POLY(POLY)) u_crc24_byte (
        .crc_in  (crc_seed),
        .byte_in (data_in),
        .crc_out (crc_nxt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= 10'd0;
            crc           <= 24'h000000;
            data_out      <= 8'h00;
            out_valid     <= 1'b0;
            CRC_start     <= 1'b0;
            CRC_blocksize <= 1'b0;
            CRC_end       <= 1'b0;
            err           <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            CRC_start <= 1'b0;
            CRC_end   <= 1'b0;
            err       <= 1'b0;
            case (state)
                IDLE: begin
                    if (xfer) begin
                        if (in_start) begin
                            CRC_blocksize <= in_blocksize;
                            cnt           <= 10'd1;
                            crc           <= crc_nxt;
                            data_out      <= data_in;
                            out_valid     <= 1'b1;
                            CRC_start     <= 1'b1;
                            state         <= PAYLOAD;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                PAYLOAD: begin
                    if (xfer) begin
                        cnt       <= cnt_inc;
                        crc       <= crc_nxt;
                        data_out  <= data_in;
                        out_valid <= 1'b1;
                        err       <= in_start;
                        if (cnt_inc == limit) begin
                            state <= CRC0;
                        end
                    end
                end
                CRC0: begin
                    data_out  <= crc[23:16];
                    out_valid <= 1'b1;
                    state     <= CRC1;
                end
                CRC1: begin
                    data_out  <= crc[15:8];
                    out_valid <= 1'b1;
                    state     <= CRC2;
                end
                CRC2: begin
                    data_out  <= crc[7:0];
                    out_valid <= 1'b1;
                    CRC_end   <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crc24_attach.sv
// Directed bench for crc24_attach with a cycle-by-cycle expected-output scoreboard.
module tb_crc24_attach;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       in_valid;
    logic       in_start;
    logic       in_blocksize;
    logic       in_ready;
    logic       ds_ready;
    logic [7:0] data_out;
    logic       out_valid;
    logic       CRC_start;
    logic       CRC_blocksize;
    logic       CRC_end;
    logic       err;

    always #5 clk = ~clk;

    crc24_attach dut (
        .clk           (clk),
        .reset         (reset),
        .data_in       (data_in),
        .in_valid      (in_valid),
        .in_start      (in_start),
        .in_blocksize  (in_blocksize),
        .in_ready      (in_ready),
        .ds_ready      (ds_ready),
        .data_out      (data_out),
        .out_valid     (out_valid),
        .CRC_start     (CRC_start),
        .CRC_blocksize (CRC_blocksize),
        .CRC_end       (CRC_end),
        .err           (err)
    );

    typedef struct packed {
        logic       v;
        logic [7:0] d;
        logic       s;
        logic       e;
        logic       bs;
        logic       er;
    } exp_t;

    exp_t exp_q[$];
    exp_t pend_q[$];

    int          total = 0;
    int          bad   = 0;
    int          m_state = 0;
    int          m_cnt   = 0;
    logic        m_bs    = 1'b0;
    logic [23:0] m_crc   = 24'h0;
    int          blk_cnt = 0;
    int          blk_len = 0;
    logic [23:0] last3   = 24'h0;

    function automatic logic [23:0] m_upd(input logic [23:0] c, input logic [7:0] b);
        logic [23:0] r;
        r = c;
        for (int i = 7; i >= 0; i--)
            r = (r[23] ^ b[i]) ? ((r << 1) ^ 24'h800063) : (r << 1);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic cyc(input logic v, input logic s, input logic bs,
                       input logic [7:0] d, input logic dsr);
        logic exp_rdy;
        logic x;
        exp_t e;
        in_valid = v; in_start = s; in_blocksize = bs; data_in = d; ds_ready = dsr;
        #1;
        exp_rdy = (m_state == 0) ? dsr : (m_state == 1);
        chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
        x = v & exp_rdy;
        e = '0;
        if (m_state == 2) begin
            e = pend_q.pop_front();
            if (pend_q.size() == 0) m_state = 0;
        end else if (x) begin
            if (m_state == 0) begin
                if (s) begin
                    m_bs = bs; m_cnt = 1; m_crc = m_upd(24'h0, d);
                    e.v = 1'b1; e.d = d; e.s = 1'b1; e.bs = bs;
                    m_state = 1;
                end else begin
                    e.er = 1'b1;
                end
            end else begin
                m_cnt++;
                m_crc = m_upd(m_crc, d);
                e.v = 1'b1; e.d = d; e.er = s; e.bs = m_bs;
                if (m_cnt == (m_bs ? turbo_pkg::PAY_LARGE : turbo_pkg::PAY_SMALL)) begin
                    pend_q.push_back('{1'b1, m_crc[23:16], 1'b0, 1'b0, m_bs, 1'b0});
                    pend_q.push_back('{1'b1, m_crc[15:8],  1'b0, 1'b0, m_bs, 1'b0});
                    pend_q.push_back('{1'b1, m_crc[7:0],   1'b0, 1'b1, m_bs, 1'b0});
                    m_state = 2;
                end
            end
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("out_valid", {31'b0, out_valid}, {31'b0, e.v});
        chk("err", {31'b0, err}, {31'b0, e.er});
        chk("crc_start", {31'b0, CRC_start}, {31'b0, e.s});
        chk("crc_end", {31'b0, CRC_end}, {31'b0, e.e});
        if (e.v) begin
            chk("data_out", {24'b0, data_out}, {24'b0, e.d});
            chk("crc_blocksize", {31'b0, CRC_blocksize}, {31'b0, e.bs});
        end
        if (out_valid) begin
            blk_cnt = CRC_start ? 1 : blk_cnt + 1;
            last3   = {last3[15:0], data_out};
            if (CRC_end) blk_len = blk_cnt;
        end
    endtask

    // mode 0: all zero, 1: zeros then 8'h01, 2: random; gap toggles in_valid
    task automatic send_block(input logic bs, input int n, input int mode,
                              input logic gap, input int err_at);
        logic [7:0] d;
        blk_len = 0;
        for (int i = 0; i < n; i++) begin
            if (gap && i > 0) cyc(1'b0, 1'b0, bs, 8'hA5, 1'b0);
            d = (mode == 0) ? 8'h00 :
                (mode == 1) ? ((i == n - 1) ? 8'h01 : 8'h00) :
                8'($urandom_range(0, 255));
            cyc(1'b1, (i == 0) || (i == err_at), bs, d, (i == 0) ? 1'b1 : !gap);
        end
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, bs, 8'($urandom_range(0, 255)), 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
        chk({tag, "_data_out"}, {24'b0, data_out}, 32'd0);
        chk({tag, "_crc_start"}, {31'b0, CRC_start}, 32'd0);
        chk({tag, "_crc_end"}, {31'b0, CRC_end}, 32'd0);
        chk({tag, "_crc_blocksize"}, {31'b0, CRC_blocksize}, 32'd0);
        chk({tag, "_err"}, {31'b0, err}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; data_in = 8'h00; in_valid = 1'b0; in_start = 1'b0;
        in_blocksize = 1'b0; ds_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_cleared("reset");
        reset = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

        send_block(1'b0, 129, 0, 1'b0, -1);
        chk("zero_blk_len", blk_len, 32'd132);
        chk("zero_blk_crc", {8'b0, last3}, 32'h000000);

        send_block(1'b0, 129, 1, 1'b0, -1);
        chk("one_blk_len", blk_len, 32'd132);
        chk("one_blk_crc", {8'b0, last3}, 32'h800063);

        // start byte held while downstream is not ready
        repeat (3) cyc(1'b1, 1'b1, 1'b0, 8'h11, 1'b0);
        send_block(1'b0, 129, 2, 1'b0, -1);
        chk("dsr_blk_len", blk_len, 32'd132);
        chk("dsr_blk_crc", {8'b0, last3}, {8'b0, m_crc});

        send_block(1'b1, 765, 2, 1'b1, -1);
        chk("large_blk_len", blk_len, 32'd768);
        chk("large_blk_crc", {8'b0, last3}, {8'b0, m_crc});

        cyc(1'b1, 1'b0, 1'b0, 8'h33, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        send_block(1'b0, 129, 2, 1'b0, 49);
        chk("errmid_blk_len", blk_len, 32'd132);
        chk("errmid_blk_crc", {8'b0, last3}, {8'b0, m_crc});

        for (int i = 0; i < 60; i++)
            cyc(1'b1, (i == 0), 1'b0, 8'($urandom_range(0, 255)), 1'b1);
        reset = 1'b0;
        #1;
        chk_cleared("midrst");
        exp_q.delete();
        pend_q.delete();
        m_state = 0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_cleared("midrst_hold");
        reset = 1'b1;
        send_block(1'b0, 129, 2, 1'b0, -1);
        chk("after_rst_len", blk_len, 32'd132);
        chk("after_rst_crc", {8'b0, last3}, {8'b0, m_crc});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
